serial_sum_collector: RTL and testbench



---
 rtl/serial_sum_collector.sv | 122 ++++++++++++
 tb/tb_serial_sum_collector.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sum_collector.sv
// Collects the LSB-first serial sum stream and presents it as a parallel word over valid/ready.
// Build option: define SERIAL_COLLECT_PARITY_EN to register even parity over {result, carry_out}.
module serial_sum_collector #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             sum_bit,
    input  logic             carry_bit,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             overrun,
    output logic             result_parity
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;

    logic [WIDTH-1:0] w_next_word;
    logic             w_capture;

    assign w_next_word = {sum_bit, r_shreg[WIDTH-1:1]};
    // start wins over a bit presented in the same SHIFT cycle, so it blocks capture too
    assign w_capture   = (r_state == S_SHIFT) && !start && bit_valid
                         && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SHIFT;
                        r_shreg <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (start) begin
                        r_shreg <= '0;
                        r_cnt   <= '0;
                    end else if (w_capture) begin
                        r_shreg  <= w_next_word;
                        r_cnt    <= '0;
                        r_result <= w_next_word;
                        r_carry  <= carry_bit;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (bit_valid) begin
                        r_shreg <= w_next_word;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bit_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (result_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_COLLECT_PARITY_EN
    logic r_parity;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_capture) begin
            r_parity <= (^w_next_word) ^ carry_bit;
        end
    end

    assign result_parity = r_parity;
`else
    assign result_parity = 1'b0;
`endif

    assign result       = r_result;
    assign carry_out    = r_carry;
    assign result_valid = r_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Self-checking bench for serial_sum_collector: directed scenarios plus random traffic
// compared every cycle against a bit-queue reference model.
module tb_serial_sum_collector;

    localparam int WIDTH = 5;
    localparam int CNT_W = 4;

    logic             clock;
    logic             reset;
    logic             start;
    logic             bit_valid;
    logic             sum_bit;
    logic             carry_bit;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             result_valid;
    logic             result_ready;
    logic             busy;
    logic             overrun;
    logic             result_parity;

    int checks;
    int errors;

    // reference model: collection is a queue of accepted bits
    bit collecting;
    bit holding;
    bit bits_q[$];
    int exp_result;
    int exp_carry;
    int exp_ovr;
    int exp_par;

    serial_sum_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .bit_valid    (bit_valid),
        .sum_bit      (sum_bit),
        .carry_bit    (carry_bit),
        .result       (result),
        .carry_out    (carry_out),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overrun      (overrun),
        .result_parity(result_parity)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit st, input bit bv, input bit sb, input bit cb,
                                input bit rdy, input bit rst);
        int word;
        if (rst) begin
            collecting = 0;
            holding    = 0;
            bits_q.delete();
            exp_result = 0;
            exp_carry  = 0;
            exp_ovr    = 0;
            exp_par    = 0;
        end else if (holding) begin
            if (bv) exp_ovr = 1;
            if (rdy) holding = 0;
        end else if (collecting) begin
            if (st) begin
                bits_q.delete();
            end else if (bv) begin
                bits_q.push_back(sb);
                if (bits_q.size() == WIDTH) begin
                    word = 0;
                    for (int i = 0; i < WIDTH; i++) word += int'(bits_q[i]) << i;
                    exp_result = word;
                    exp_carry  = cb;
`ifdef SERIAL_COLLECT_PARITY_EN
                    exp_par = ($countones(word) + cb) % 2;
`else
                    exp_par = 0;
`endif
                    holding    = 1;
                    collecting = 0;
                    bits_q.delete();
                end
            end
        end else if (st) begin
            collecting = 1;
            bits_q.delete();
        end
    endtask

    task automatic step(input bit st, input bit bv, input bit sb, input bit cb,
                        input bit rdy, input bit rst);
        start        = st;
        bit_valid    = bv;
        sum_bit      = sb;
        carry_bit    = cb;
        result_ready = rdy;
        reset        = rst;
        @(posedge clock);
        model_update(st, bv, sb, cb, rdy, rst);
        #1;
        chk("m_result", 32'(result), 32'(exp_result));
        chk("m_carry", 32'(carry_out), 32'(exp_carry));
        chk("m_valid", 32'(result_valid), 32'(holding));
        chk("m_busy", 32'(busy), 32'(collecting));
        chk("m_overrun", 32'(overrun), 32'(exp_ovr));
        chk("m_parity", 32'(result_parity), 32'(exp_par));
    endtask

    task automatic bit_in(input bit sb, input bit cb, input bit rdy);
        step(0, 1, sb, cb, rdy, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start = 0; bit_valid = 0; sum_bit = 0; carry_bit = 0; result_ready = 0; reset = 1;

        // reset state
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_result", 32'(result), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);

        // basic word 0,1,1,0,1 carry 1 -> 22
        step(1, 0, 0, 0, 1, 0);
        chk("tp1_busy", 32'(busy), 1);
        bit_in(0, 0, 1); bit_in(1, 0, 1); bit_in(1, 0, 1); bit_in(0, 0, 1);
        chk("tp1_pre_valid", 32'(result_valid), 0);
        bit_in(1, 1, 1);
        chk("tp1_result", 32'(result), 22);
        chk("tp1_carry", 32'(carry_out), 1);
        chk("tp1_valid", 32'(result_valid), 1);
        chk("tp1_parity", 32'(result_parity), 0);
        step(0, 0, 0, 0, 1, 0);
        chk("tp1_valid_drop", 32'(result_valid), 0);
        chk("tp1_busy_after", 32'(busy), 0);
        chk("tp1_result_kept", 32'(result), 22);

        // same word with a 2-cycle bubble after the 2nd bit
        step(1, 0, 0, 0, 0, 0);
        bit_in(0, 0, 0); bit_in(1, 0, 0);
        step(0, 0, 1, 1, 0, 0); step(0, 0, 0, 1, 0, 0);
        bit_in(1, 0, 0); bit_in(0, 0, 0);
        chk("tp2_pre_valid", 32'(result_valid), 0);
        bit_in(1, 1, 0);
        chk("tp2_valid", 32'(result_valid), 1);
        chk("tp2_result", 32'(result), 22);
        step(0, 0, 0, 0, 1, 0);

        // restart after 3 bits, then 1,0,0,0,0 carry 0 -> 1
        step(1, 0, 0, 0, 0, 0);
        bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(0, 0, 0); bit_in(0, 0, 0);
        chk("tp3_pre_valid", 32'(result_valid), 0);
        bit_in(0, 0, 0);
        chk("tp3_result", 32'(result), 1);
        chk("tp3_carry", 32'(carry_out), 0);

        // held DONE with start/bit_valid pressure -> overrun
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, 0);
        chk("tp4_result", 32'(result), 19);
        chk("tp4_valid", 32'(result_valid), 1);
        chk("tp4_overrun", 32'(overrun), 1);
        step(0, 0, 0, 0, 1, 0);
        chk("tp4_valid_drop", 32'(result_valid), 0);
        chk("tp4_overrun_sticky", 32'(overrun), 1);

        // reset mid-word, then all ones with carry 1
        step(1, 0, 0, 0, 0, 0);
        bit_in(1, 0, 0); bit_in(1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("tp5_busy", 32'(busy), 0);
        chk("tp5_result", 32'(result), 0);
        chk("tp5_overrun", 32'(overrun), 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < WIDTH - 1; i++) bit_in(1, 0, 0);
        bit_in(1, 1, 0);
        chk("tp5_word", 32'(result), 31);
        chk("tp5_carry", 32'(carry_out), 1);
        chk("tp5_parity", 32'(result_parity), 0);
        step(0, 0, 0, 0, 1, 0);

        // start with bit_valid in IDLE: that bit is ignored
        step(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < WIDTH - 1; i++) bit_in(0, 0, 0);
        chk("tp6_not_yet", 32'(result_valid), 0);
        bit_in(0, 0, 0);
        chk("tp6_valid", 32'(result_valid), 1);
        chk("tp6_result", 32'(result), 0);
        step(0, 0, 0, 0, 1, 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 7),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 79) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
